// File: rtl/alu_sequencer_if.sv
// Bundle of the instruction port, the ALU bgn/rdy bus, status pulses and debug read port.
// The sequencer takes the master side; the decoder/ALU environment takes the slave side.
interface alu_sequencer_if;
   logic        ins_valid;
   logic        ins_ready;
   logic [5:0]  ins_op;
   logic [2:0]  ins_rd;
   logic [2:0]  ins_ra;
   logic [2:0]  ins_rb;
   logic        ins_imm_en;
   logic [15:0] ins_imm;

   logic        alu_bgn;
   logic [5:0]  alu_opcode;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_acc1;
   logic [15:0] alu_acc2;
   logic        alu_zero;
   logic        alu_negative;
   logic        alu_carry;
   logic        alu_overflow;
   logic        alu_rdy;

   logic [3:0]  flags;
   logic        done;
   logic        err_timeout;
   logic        err_illegal;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   modport master (
      input  ins_valid, ins_op, ins_rd, ins_ra, ins_rb, ins_imm_en, ins_imm,
      input  alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow, alu_rdy,
      input  dbg_addr,
      output ins_ready, alu_bgn, alu_opcode, alu_a, alu_b,
      output flags, done, err_timeout, err_illegal, dbg_data
   );

   modport slave (
      output ins_valid, ins_op, ins_rd, ins_ra, ins_rb, ins_imm_en, ins_imm,
      output alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow, alu_rdy,
      output dbg_addr,
      input  ins_ready, alu_bgn, alu_opcode, alu_a, alu_b,
      input  flags, done, err_timeout, err_illegal, dbg_data
   );
endinterface

// File: rtl/alu_sequencer.sv
// Issue controller for the ALU: owns the 8x16 register file and the flag register,
// issues one instruction at a time over the bgn/rdy handshake and writes results back.
module alu_sequencer #(
   parameter int TIMEOUT = 64
) (
   input logic             clk,
   input logic             rst_n,
   alu_sequencer_if.master bus
);

   localparam int CntW = $clog2(TIMEOUT + 1);

   // ALU opcode encoding: ADD=1 SUB=2 MUL=3 DIV=4 MOD=5 LSR=6 LSL=7 RSR=8 RSL=9
   // AND=10 OR=11 XOR=12 NOT=13 CMP=14 TST=15 INC=16 DEC=17 NOP=31
   localparam logic [5:0] OpMul = 6'd3;
   localparam logic [5:0] OpDiv = 6'd4;
   localparam logic [5:0] OpMod = 6'd5;
   localparam logic [5:0] OpCmp = 6'd14;
   localparam logic [5:0] OpTst = 6'd15;
   localparam logic [5:0] OpDec = 6'd17;
   localparam logic [5:0] OpNop = 6'd31;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StWb
   } state_t;

   state_t          state_q;
   logic [15:0]     regFile_q [8];
   logic [2:0]      rd_q;
   logic [5:0]      opcode_q;
   logic [15:0]     aluA_q;
   logic [15:0]     aluB_q;
   logic [15:0]     acc1_q;
   logic [15:0]     acc2_q;
   logic [3:0]      aluFlags_q;
   logic [3:0]      flags_q;
   logic            seenLow_q;
   logic            bgn_q;
   logic            done_q;
   logic            errTimeout_q;
   logic            errIllegal_q;
   logic [CntW-1:0] waitCnt_q;

   logic            opLegal;
   logic [15:0]     operandB;
   logic            rdyQualified;
   logic            waitExpired;
   logic            writesPair;
   logic            writesAcc1;

   always_comb begin
      opLegal      = ((bus.ins_op != 6'd0) && (bus.ins_op <= OpDec)) || (bus.ins_op == OpNop);
      operandB     = bus.ins_imm_en ? bus.ins_imm : regFile_q[bus.ins_rb];
      // A rdy still high from the previous operation must not be mistaken for this one's result.
      rdyQualified = bus.alu_rdy && seenLow_q;
      waitExpired  = (waitCnt_q == CntW'(TIMEOUT - 1));
      writesPair   = (opcode_q == OpMul) || (opcode_q == OpDiv) || (opcode_q == OpMod);
      writesAcc1   = !((opcode_q == OpCmp) || (opcode_q == OpTst) || (opcode_q == OpNop));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         for (int i = 0; i < 8; i++) regFile_q[i] <= '0;
         rd_q         <= '0;
         opcode_q     <= '0;
         aluA_q       <= '0;
         aluB_q       <= '0;
         acc1_q       <= '0;
         acc2_q       <= '0;
         aluFlags_q   <= '0;
         flags_q      <= '0;
         seenLow_q    <= 1'b0;
         bgn_q        <= 1'b0;
         done_q       <= 1'b0;
         errTimeout_q <= 1'b0;
         errIllegal_q <= 1'b0;
         waitCnt_q    <= '0;
      end else begin
         bgn_q        <= 1'b0;
         done_q       <= 1'b0;
         errTimeout_q <= 1'b0;
         errIllegal_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.ins_valid) begin
                  if (opLegal) begin
                     opcode_q <= bus.ins_op;
                     rd_q     <= bus.ins_rd;
                     aluA_q   <= regFile_q[bus.ins_ra];
                     aluB_q   <= operandB;
                     bgn_q    <= 1'b1;
                     state_q  <= StIssue;
                  end else begin
                     errIllegal_q <= 1'b1;
                  end
               end
            end
            StIssue: begin
               seenLow_q <= 1'b0;
               waitCnt_q <= '0;
               state_q   <= StWait;
            end
            StWait: begin
               if (rdyQualified) begin
                  acc1_q     <= bus.alu_acc1;
                  acc2_q     <= bus.alu_acc2;
                  aluFlags_q <= {bus.alu_zero, bus.alu_negative, bus.alu_carry, bus.alu_overflow};
                  done_q     <= 1'b1;
                  state_q    <= StWb;
               end else begin
                  if (!bus.alu_rdy) seenLow_q <= 1'b1;
                  if (waitExpired) begin
                     errTimeout_q <= 1'b1;
                     opcode_q     <= '0;
                     state_q      <= StIdle;
                  end else begin
                     waitCnt_q <= waitCnt_q + CntW'(1);
                  end
               end
            end
            StWb: begin
               if (writesAcc1) regFile_q[rd_q] <= acc1_q;
               if (writesPair) regFile_q[rd_q + 3'd1] <= acc2_q;
               if (opcode_q != OpNop) flags_q <= aluFlags_q;
               opcode_q <= '0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ins_ready   = (state_q == StIdle);
   assign bus.alu_bgn     = bgn_q;
   assign bus.alu_opcode  = opcode_q;
   assign bus.alu_a       = aluA_q;
   assign bus.alu_b       = aluB_q;
   assign bus.flags       = flags_q;
   assign bus.done        = done_q;
   assign bus.err_timeout = errTimeout_q;
   assign bus.err_illegal = errIllegal_q;
   assign bus.dbg_data    = regFile_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a directed table of instructions plus random instructions,
// with the ALU played by the bench and results checked against a register/flag model.
module tb_alu_sequencer;

   localparam logic [5:0] OpAdd = 6'd1,  OpSub = 6'd2,  OpMul = 6'd3,  OpDiv = 6'd4;
   localparam logic [5:0] OpMod = 6'd5,  OpLsr = 6'd6,  OpLsl = 6'd7,  OpRsr = 6'd8;
   localparam logic [5:0] OpRsl = 6'd9,  OpAnd = 6'd10, OpOr  = 6'd11, OpXor = 6'd12;
   localparam logic [5:0] OpNot = 6'd13, OpCmp = 6'd14, OpTst = 6'd15, OpInc = 6'd16;
   localparam logic [5:0] OpDec = 6'd17, OpNop = 6'd31;
   localparam int TimeoutCycles = 64;
   localparam int ModeNormal = 0;
   localparam int ModeNoRdy  = 1;
   localparam int ModeReset  = 2;

   typedef struct {
      logic [5:0]  op;
      logic [2:0]  rd;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic        immEn;
      logic [15:0] imm;
      int          stale;
      int          low;
      int          mode;
      int          chkIdx;
      logic [15:0] chkVal;
      int          chkFlags;
   } vec_t;

   logic clk;
   logic rst_n;
   alu_sequencer_if bus ();

   alu_sequencer #(.TIMEOUT(TimeoutCycles)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int          checkCount = 0;
   int          passCount = 0;
   logic [15:0] model [8];
   logic [3:0]  modelFlags;
   vec_t        vecs [$];

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit isLegal(input logic [5:0] op);
      return ((op >= 6'd1) && (op <= 6'd17)) || (op == 6'd31);
   endfunction

   // What a well-behaved ALU would return for each operation.
   function automatic void aluRef(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r1, output logic [15:0] r2, output logic [3:0] fl);
      logic [16:0] s;
      logic [31:0] w;
      logic        c;
      logic        v;
      r1 = 16'd0; r2 = 16'd0; c = 1'b0; v = 1'b0;
      case (op)
         OpAdd: begin
            s = {1'b0, a} + {1'b0, b};
            r1 = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r1[15] != a[15]);
         end
         OpSub, OpCmp: begin
            r1 = a - b; c = (a < b);
            v = (a[15] != b[15]) && (r1[15] != a[15]);
         end
         OpMul: begin w = {16'd0, a} * {16'd0, b}; r1 = w[15:0]; r2 = w[31:16]; end
         OpDiv: begin
            if (b == 16'd0) begin r1 = 16'hFFFF; r2 = a; end
            else begin r1 = a / b; r2 = a % b; end
         end
         OpMod: r1 = (b == 16'd0) ? a : a % b;
         OpLsr: r1 = a >> b[3:0];
         OpLsl: r1 = a << b[3:0];
         OpRsr: begin w = {a, a} >> b[3:0]; r1 = w[15:0]; end
         OpRsl: begin w = {a, a} << b[3:0]; r1 = w[31:16]; end
         OpAnd, OpTst: r1 = a & b;
         OpOr:  r1 = a | b;
         OpXor: r1 = a ^ b;
         OpNot: r1 = ~a;
         OpInc: r1 = a + 16'd1;
         OpDec: r1 = a - 16'd1;
         default: r1 = 16'hDEAD;
      endcase
      fl = {(r1 == 16'd0), r1[15], c, v};
      if (op == OpNop) fl = 4'b0111;
   endfunction

   function automatic vec_t mk(input logic [5:0] op, input int rd, input int ra, input int rb,
                               input logic immEn, input logic [15:0] imm, input int stale, input int low,
                               input int mode, input int chkIdx, input logic [15:0] chkVal, input int chkFlags);
      vec_t v;
      v.op = op; v.rd = 3'(rd); v.ra = 3'(ra); v.rb = 3'(rb);
      v.immEn = immEn; v.imm = imm; v.stale = stale; v.low = low; v.mode = mode;
      v.chkIdx = chkIdx; v.chkVal = chkVal; v.chkFlags = chkFlags;
      return v;
   endfunction

   task automatic setAlu(input logic rdy, input logic [15:0] r1, input logic [15:0] r2, input logic [3:0] fl);
      bus.alu_rdy      = rdy;
      bus.alu_acc1     = r1;
      bus.alu_acc2     = r2;
      bus.alu_zero     = fl[3];
      bus.alu_negative = fl[2];
      bus.alu_carry    = fl[1];
      bus.alu_overflow = fl[0];
   endtask

   task automatic checkState(input string tag);
      for (int i = 0; i < 8; i++) begin
         bus.dbg_addr = 3'(i);
         #1;
         checkOutput($sformatf("%s r%0d", tag, i), {16'd0, bus.dbg_data}, {16'd0, model[i]});
      end
      checkOutput({tag, " flags"}, {28'd0, bus.flags}, {28'd0, modelFlags});
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      logic [15:0] a, b, r1, r2;
      logic [3:0]  fl;
      bit          legal;
      int          doneAt, toAt, illAt, bgnCount, doneCount, toCount, limit, expDone;
      logic        readyAtTo, readyAfter;
      logic [5:0]  opAfter;
      legal = isLegal(v.op);
      a = model[v.ra];
      b = v.immEn ? v.imm : model[v.rb];
      aluRef(v.op, a, b, r1, r2, fl);
      expDone = v.stale + v.low + 3;
      for (int i = 0; i < 100 && !bus.ins_ready; i++) tick;
      checkOutput({tag, " ready_in"}, 32'(bus.ins_ready), 32'd1);

      bus.ins_valid = 1'b1; bus.ins_op = v.op; bus.ins_rd = v.rd; bus.ins_ra = v.ra;
      bus.ins_rb = v.rb; bus.ins_imm_en = v.immEn; bus.ins_imm = v.imm;
      tick;
      bus.ins_valid = 1'b0; bus.ins_op = 6'($urandom); bus.ins_imm = 16'($urandom);

      doneAt = -1; toAt = -1; illAt = -1; bgnCount = 0; doneCount = 0; toCount = 0;
      readyAtTo = 1'b0; readyAfter = 1'b0; opAfter = 6'd0;
      limit = !legal ? 4 : (v.mode == ModeNoRdy) ? TimeoutCycles + 6 : (v.mode == ModeReset) ? 12 : 40;
      for (int c = 1; c <= limit; c++) begin
         if (bus.alu_bgn) bgnCount++;
         if (bus.done) begin doneCount++; if (doneAt < 0) doneAt = c; end
         if (bus.err_timeout) begin
            toCount++;
            if (toAt < 0) begin toAt = c; readyAtTo = bus.ins_ready; end
         end
         if (bus.err_illegal && illAt < 0) illAt = c;
         if (legal && c == 1) begin
            checkOutput({tag, " alu_opcode"}, 32'(bus.alu_opcode), 32'(v.op));
            checkOutput({tag, " alu_a"}, 32'(bus.alu_a), 32'(a));
            checkOutput({tag, " alu_b"}, 32'(bus.alu_b), 32'(b));
         end
         readyAfter = bus.ins_ready;
         opAfter = bus.alu_opcode;
         if (v.mode == ModeNormal && doneAt >= 0 && c == doneAt + 1) break;
         if (legal) begin
            case (v.mode)
               ModeNormal: begin
                  if (c >= 2) begin
                     if (c < 2 + v.stale) setAlu(1'b1, ~r1, ~r2, ~fl);
                     else if (c < 2 + v.stale + v.low) setAlu(1'b0, ~r1, ~r2, ~fl);
                     else setAlu(1'b1, r1, r2, fl);
                  end
               end
               ModeNoRdy: if (c >= 2) setAlu(1'b0, r1, r2, fl);
               default: begin
                  if (c == 2) setAlu(1'b0, r1, r2, fl);
                  else if (c == 3) rst_n = 1'b0;
                  else if (c == 4) begin rst_n = 1'b1; setAlu(1'b1, r1, r2, fl); end
               end
            endcase
         end
         tick;
      end

      if (!legal) begin
         checkOutput({tag, " err_illegal_at"}, 32'(illAt), 32'd1);
         checkOutput({tag, " bgn_count"}, 32'(bgnCount), 32'd0);
         checkOutput({tag, " done_count"}, 32'(doneCount), 32'd0);
      end else if (v.mode == ModeNormal) begin
         checkOutput({tag, " done_at"}, 32'(doneAt), 32'(expDone));
         checkOutput({tag, " done_count"}, 32'(doneCount), 32'd1);
         checkOutput({tag, " bgn_count"}, 32'(bgnCount), 32'd1);
         checkOutput({tag, " ready_after"}, 32'(readyAfter), 32'd1);
         checkOutput({tag, " opcode_after"}, 32'(opAfter), 32'd0);
      end else if (v.mode == ModeNoRdy) begin
         checkOutput({tag, " timeout_at"}, 32'(toAt), 32'(TimeoutCycles + 2));
         checkOutput({tag, " timeout_count"}, 32'(toCount), 32'd1);
         checkOutput({tag, " done_count"}, 32'(doneCount), 32'd0);
         checkOutput({tag, " ready_at_timeout"}, 32'(readyAtTo), 32'd1);
      end else begin
         checkOutput({tag, " done_count"}, 32'(doneCount), 32'd0);
         checkOutput({tag, " bgn_count"}, 32'(bgnCount), 32'd1);
         checkOutput({tag, " opcode_after"}, 32'(opAfter), 32'd0);
      end

      if (legal && v.mode == ModeNormal) begin
         if (v.op == OpMul || v.op == OpDiv || v.op == OpMod) begin
            model[v.rd] = r1;
            model[3'(v.rd + 3'd1)] = r2;
         end else if (!(v.op == OpCmp || v.op == OpTst || v.op == OpNop)) begin
            model[v.rd] = r1;
         end
         if (v.op != OpNop) modelFlags = fl;
      end else if (legal && v.mode == ModeReset) begin
         for (int i = 0; i < 8; i++) model[i] = 16'd0;
         modelFlags = 4'd0;
      end

      checkState(tag);
      if (v.chkIdx >= 0) begin
         bus.dbg_addr = 3'(v.chkIdx);
         #1;
         checkOutput({tag, " table_reg"}, 32'(bus.dbg_data), 32'(v.chkVal));
      end
      if (v.chkFlags >= 0) checkOutput({tag, " table_flags"}, 32'(bus.flags), 32'(v.chkFlags));
      tick;
   endtask

   initial begin
      vec_t v;
      int   k;
      rst_n = 1'b0;
      bus.ins_valid = 1'b0; bus.ins_op = 6'd0; bus.ins_rd = 3'd0; bus.ins_ra = 3'd0;
      bus.ins_rb = 3'd0; bus.ins_imm_en = 1'b0; bus.ins_imm = 16'd0; bus.dbg_addr = 3'd0;
      setAlu(1'b0, 16'd0, 16'd0, 4'd0);
      for (int i = 0; i < 8; i++) model[i] = 16'd0;
      modelFlags = 4'd0;

      // op, rd, ra, rb, immEn, imm, stale, low, mode, chkIdx, chkVal, chkFlags
      vecs.push_back(mk(OpAdd, 1, 0, 0, 1'b1, 16'd5,      0, 1, ModeNormal, 1, 16'd5,      -1));
      vecs.push_back(mk(OpAdd, 2, 0, 0, 1'b1, 16'd3,      1, 1, ModeNormal, 2, 16'd3,      -1));
      vecs.push_back(mk(OpAdd, 3, 1, 2, 1'b0, 16'd0,      0, 1, ModeNormal, 3, 16'd8,       0));
      vecs.push_back(mk(OpAdd, 1, 0, 0, 1'b1, 16'd7,      0, 2, ModeNormal, 1, 16'd7,      -1));
      vecs.push_back(mk(OpAdd, 2, 0, 0, 1'b1, 16'd7,      2, 1, ModeNormal, 2, 16'd7,      -1));
      vecs.push_back(mk(OpAdd, 4, 0, 0, 1'b1, 16'h0055,   0, 1, ModeNormal, 4, 16'h0055,   -1));
      vecs.push_back(mk(OpCmp, 4, 1, 2, 1'b0, 16'd0,      1, 1, ModeNormal, 4, 16'h0055,    8));
      vecs.push_back(mk(OpNop, 0, 0, 0, 1'b0, 16'd0,      1, 1, ModeNormal, 0, 16'd0,       8));
      vecs.push_back(mk(OpAdd, 1, 0, 0, 1'b1, 16'h1234,   0, 1, ModeNormal, 1, 16'h1234,   -1));
      vecs.push_back(mk(OpMul, 7, 1, 0, 1'b1, 16'h0100,   0, 1, ModeNormal, 0, 16'h0012,   -1));
      vecs.push_back(mk(OpAdd, 5, 2, 4, 1'b0, 16'd0,      3, 1, ModeNormal, 5, 16'h005C,   -1));
      vecs.push_back(mk(OpSub, 6, 4, 2, 1'b0, 16'd0,      3, 2, ModeNormal, 6, 16'h004E,    0));
      vecs.push_back(mk(OpAdd, 3, 1, 2, 1'b0, 16'd0,      0, 0, ModeNoRdy,  3, 16'd8,       0));
      vecs.push_back(mk(6'd20, 3, 1, 2, 1'b0, 16'd0,      0, 1, ModeNormal, 3, 16'd8,       0));
      vecs.push_back(mk(OpAdd, 3, 1, 2, 1'b0, 16'd0,      0, 1, ModeReset,  3, 16'd0,       0));
      vecs.push_back(mk(OpAdd, 1, 0, 0, 1'b1, 16'd9,      0, 1, ModeNormal, 1, 16'd9,      -1));

      tick;
      tick;
      checkOutput("reset ins_ready", 32'(bus.ins_ready), 32'd1);
      checkOutput("reset alu_bgn", 32'(bus.alu_bgn), 32'd0);
      checkOutput("reset alu_opcode", 32'(bus.alu_opcode), 32'd0);
      checkOutput("reset alu_a", 32'(bus.alu_a), 32'd0);
      checkOutput("reset alu_b", 32'(bus.alu_b), 32'd0);
      checkOutput("reset done", 32'(bus.done), 32'd0);
      checkOutput("reset err_timeout", 32'(bus.err_timeout), 32'd0);
      checkOutput("reset err_illegal", 32'(bus.err_illegal), 32'd0);
      checkState("reset");
      tick;
      rst_n = 1'b1;
      tick;

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("dir%0d", i));

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            do k = $urandom_range(0, 63); while (isLegal(6'(k)));
         end else begin
            k = $urandom_range(0, 17);
            k = (k == 17) ? 31 : k + 1;
         end
         v = mk(6'(k), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom), 16'($urandom), $urandom_range(0, 2), $urandom_range(1, 3),
                ModeNormal, -1, 16'd0, -1);
         applyStimulus(v, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue controller that drives the ALU from the initiator side of its `bgn`/`rdy` handshake. It accepts one instruction at a time and reads operands from an internal 8×16 register file. It issues the operation to the ALU, waits for a qualified `rdy`, then writes results and flags back. It sits between the instruction decoder and the ALU and owns the architectural registers and the flag register.

## Interface
- `TIMEOUT`, 64, maximum WAIT cycles before abort (≥2)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ins_valid`  in  1  instruction present
- `ins_ready`  out  1  sequencer can accept (IDLE only)
- `ins_op`  in  6  opcode, ALU encoding (ADD=1 … DEC=17, NOP=31)
- `ins_rd`, `ins_ra`, `ins_rb`  in  3 each  dest / source A / source B register index
- `ins_imm_en`  in  1  use `ins_imm` instead of `reg[ins_rb]` as B
- `ins_imm`  in  16  immediate B operand
- `alu_bgn`  out  1  start pulse to ALU
- `alu_opcode`  out  6  opcode to ALU
- `alu_a`, `alu_b`  out  16 each  operands to ALU
- `alu_acc1`, `alu_acc2`  in  16 each  ALU results
- `alu_zero`, `alu_negative`, `alu_carry`, `alu_overflow`  in  1 each  ALU flags
- `alu_rdy`  in  1  ALU result valid (level)
- `flags`  out  4  registered {Z,N,C,V}
- `done`  out  1  one-cycle pulse, instruction retired
- `err_timeout`  out  1  one-cycle pulse, ALU did not respond
- `err_illegal`  out  1  one-cycle pulse, opcode not in defined set
- `dbg_addr`  in  3  debug read index
- `dbg_data`  out  16  combinational `reg[dbg_addr]`

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: `ins_ready`=1. On `ins_valid`, latch op, rd, A=`reg[ra]`, B=`ins_imm_en`?`ins_imm`:`reg[rb]`.
  - Legal opcode → ISSUE.
  - Illegal opcode (0, 18–30, 32–63) → pulse `err_illegal` next cycle, stay IDLE, no writes.
- ISSUE (1 cycle): `alu_bgn`=1. `alu_opcode`/`alu_a`/`alu_b` drive the latched values and hold them stable through WAIT. → WAIT.
- WAIT: `alu_rdy` is qualified only after it has been sampled low at least once in WAIT (`seen_low` flag cleared in ISSUE). This rejects the stale `rdy` left high by the previous operation.
  - Qualified `rdy`=1 → capture acc1, acc2 and the four flags; → WB.
  - Cycle counter reaches `TIMEOUT` → pulse `err_timeout`; no write, flags unchanged; → IDLE.
- WB (1 cycle): `done`=1 and register writes:
  - ADD, SUB, LSR, LSL, RSR, RSL, AND, OR, XOR, NOT, INC, DEC: `reg[rd]`←acc1.
  - MUL, DIV, MOD: `reg[rd]`←acc1 and `reg[(rd+1) mod 8]`←acc2.
  - CMP, TST: no register write.
  - NOP: no register write, flags unchanged.
  - All others (including CMP, TST): `flags`←{zero,negative,carry,overflow}.
  - → IDLE; after WB, `alu_opcode` returns to 0.
- All 8 registers are writable, including r0; there is no hardwired zero.
- Register indices wrap mod 8. Widths are 16 bits throughout, with no extension.

## Timing
- Reset (async assert, sync deassert use): state IDLE, all 8 registers 0, `flags`=0, `alu_bgn`=0, `alu_opcode`=0, `alu_a`=`alu_b`=0, `done`/`err_*`=0, `ins_ready`=1.
- Accept in cycle T. `alu_bgn`=1 in T+1. WAIT from T+2.
- Qualified `rdy` sampled in cycle W → WB in W+1 (`done`, write visible on `dbg_data` in W+2) → `ins_ready`=1 in W+2.
- Minimum latency: `rdy` low at T+2 and high at T+3 gives `done` at T+4. Back-to-back throughput is one instruction per 5 cycles minimum.
- Timeout: `err_timeout` is asserted in the cycle after the counter hits `TIMEOUT` (counter starts at 0 in the first WAIT cycle). IDLE follows in that same cycle.
- Reset mid-WAIT aborts with no writeback. A late ALU `rdy` after reset is ignored, because `seen_low` was cleared.
- `ins_valid` outside IDLE is ignored; the instruction must be held until `ins_ready`.

## Test plan
- r1=5, r2=3, ADD rd=r3,ra=r1,rb=r2; ALU model `rdy` low 1 cycle then high → `done` at T+4, r3=8, flags Z=0,N=0.
- r1=0x1234, imm 0x0100, MUL rd=r7 with model acc1=0x3400, acc2=0x0012 → r7=0x3400, r0=0x0012 (wrap).
- r1=7, r2=7, CMP rd=r4; model zero=1 → `flags`[3]=1, r4 unchanged; then NOP → `flags` still 0b1000.
- Back-to-back: ADD then SUB, model leaves `rdy` high between ops → SUB waits for `rdy` low→high; no early capture; both results correct.
- ALU model never asserts `rdy`, `TIMEOUT`=64 → `err_timeout` exactly once, at T+2+64; registers and flags unchanged; `ins_ready`=1 next.
- `rst_n` low in WAIT, then model `rdy` high → all registers 0, no `done`. Also: opcode 20 accepted → `err_illegal` at T+1, `alu_bgn` never asserted.
